// File: rtl/reduce_sweep_pkg.sv
// rtl/reduce_sweep_pkg.sv - shared constants for the reduction-gate sweep checker
package reduce_sweep_pkg;

  // Sweep FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Bit positions inside first_err_mask, ordered {and, or, xor}
  localparam int MASK_AND_BIT = 2;
  localparam int MASK_OR_BIT  = 1;
  localparam int MASK_XOR_BIT = 0;

  // Default gate input width
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/reduce_sweep_checker_if.sv
// rtl/reduce_sweep_checker_if.sv - stimulus/response bus between the checker and the gates
interface reduce_sweep_checker_if
  import reduce_sweep_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] vec_out;
  logic             and_in;
  logic             or_in;
  logic             xor_in;

  // Checker side: drives the vector, consumes gate results
  modport master (output vec_out, input and_in, or_in, xor_in);
  // Gate side: consumes the vector, drives gate results
  modport slave  (input vec_out, output and_in, or_in, xor_in);
endinterface

// File: rtl/reduce_sweep_checker_ref.sv
// rtl/reduce_sweep_checker_ref.sv - combinational golden model of the reduction gates
module reduce_ref #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic             exp_and,
  output logic             exp_or,
  output logic             exp_xor
);

  assign exp_and = &vec;
  assign exp_or  = |vec;
  assign exp_xor = ^vec;

endmodule

// File: rtl/reduce_sweep_checker.sv
// rtl/reduce_sweep_checker.sv - exhaustive sweep and compare of the reduction gates (option: SWEEP_STOP_ON_ERR_EN)
module reduce_sweep_checker
  import reduce_sweep_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  reduce_sweep_checker_if.master gate,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [WIDTH:0]         err_count,
  output logic [WIDTH-1:0]       first_err_vec,
  output logic [2:0]             first_err_mask,
  output logic                   first_err_valid
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0]       state;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] vec_q;
  logic             exp_and, exp_or, exp_xor;
  logic [2:0]       fail_mask;
  logic             mismatch;
  logic             last_vec;

  reduce_ref #(.WIDTH(WIDTH)) u_ref (
    .vec     (vec_q),
    .exp_and (exp_and),
    .exp_or  (exp_or),
    .exp_xor (exp_xor)
  );

  assign gate.vec_out = vec_q;
  assign busy         = (state == ST_APPLY) || (state == ST_CHECK);
  assign done         = (state == ST_FINISH);
  assign last_vec     = (vec_q == '1);

  // Per-output disagreement between the gates and the golden model
  always_comb begin
    fail_mask               = 3'b000;
    fail_mask[MASK_AND_BIT] = gate.and_in ^ exp_and;
    fail_mask[MASK_OR_BIT]  = gate.or_in  ^ exp_or;
    fail_mask[MASK_XOR_BIT] = gate.xor_in ^ exp_xor;
    mismatch                = |fail_mask;
  end

  // Sweep sequencing, error accounting and first-failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      settle_cnt      <= 4'd0;
      vec_q           <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_mask  <= 3'b000;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          vec_q      <= '0;
          settle_cnt <= 4'd0;
          if (start) begin
            state           <= ST_APPLY;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_mask  <= 3'b000;
            first_err_valid <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + (WIDTH+1)'(1);
            if (!first_err_valid) begin
              first_err_vec   <= vec_q;
              first_err_mask  <= fail_mask;
              first_err_valid <= 1'b1;
            end
          end
`ifdef SWEEP_STOP_ON_ERR_EN
          if (last_vec || mismatch) begin
`else
          if (last_vec) begin
`endif
            vec_q <= '0;
            state <= ST_FINISH;
          end else begin
            vec_q <= vec_q + WIDTH'(1);
            state <= ST_APPLY;
          end
        end
        ST_FINISH: begin
          // err_count already includes the final CHECK update here
          pass  <= (err_count == '0);
          vec_q <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
